// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - N-digit multiplexed common-anode 7-segment driver
// Double-buffered hex display with blank/DP masks, leading-zero blanking, PWM and dead time.
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int DIV_BITS    = 18,
    parameter int BRIGHT_BITS = 4,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [BRIGHT_BITS-1:0]  bright,
    input  logic                    lz_en,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              seg_n
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_BITS-1:0] DEAD     = DIV_BITS'(DEAD_CYCLES);

    logic [DIV_BITS-1:0]     div_cnt;
    logic [IDX_W-1:0]        digit_idx;

    logic [4*NUM_DIGITS-1:0] sh_value,  act_value;
    logic [NUM_DIGITS-1:0]   sh_dp,     act_dp;
    logic [NUM_DIGITS-1:0]   sh_blank,  act_blank;
    logic [BRIGHT_BITS-1:0]  sh_bright, act_bright;
    logic                    sh_lz,     act_lz;
    logic                    pending;

    logic                    fb;
    logic                    run_zero;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_lz;
    logic                    on;
    logic [6:0]              pat;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [7:0]              seg_next;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign fb = (digit_idx == LAST_IDX) && (&div_cnt);

    // Digit 0 lives in the top nibble / top mask bit; walk left to right for the zero prefix.
    always_comb begin
        run_zero  = 1'b1;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            run_zero = run_zero && (act_value[4*(NUM_DIGITS-1-i) +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                cur_nib   = act_value[4*(NUM_DIGITS-1-i) +: 4];
                cur_dp    = act_dp[NUM_DIGITS-1-i];
                cur_blank = act_blank[NUM_DIGITS-1-i];
                cur_lz    = act_lz && run_zero && (i != NUM_DIGITS - 1);
            end
        end
    end

    always_comb begin
        on = (div_cnt >= DEAD)
          && (div_cnt[DIV_BITS-1 -: BRIGHT_BITS] < act_bright)
          && !cur_blank && !cur_lz;
        pat     = hex7(cur_nib);
        an_next = '1;
        if (on)
            an_next[digit_idx] = 1'b0;
        seg_next = on ? ~{pat[0], pat[1], pat[2], pat[3], pat[4], pat[5], pat[6], cur_dp}
                      : 8'hFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            sh_value    <= '0;
            sh_dp       <= '0;
            sh_blank    <= '0;
            sh_bright   <= '0;
            sh_lz       <= 1'b0;
            act_value   <= '0;
            act_dp      <= '0;
            act_blank   <= '0;
            act_bright  <= '0;
            act_lz      <= 1'b0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
            an_n        <= '1;
            seg_n       <= 8'hFF;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (&div_cnt)
                digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;

            load_ack <= 1'b0;
            if (load) begin
                sh_value  <= value;
                sh_dp     <= dp_mask;
                sh_blank  <= blank_mask;
                sh_bright <= bright;
                sh_lz     <= lz_en;
            end
            // Swap only at the frame boundary; a coincident load bypasses the shadow.
            if (fb && load) begin
                act_value  <= value;
                act_dp     <= dp_mask;
                act_blank  <= blank_mask;
                act_bright <= bright;
                act_lz     <= lz_en;
                pending    <= 1'b0;
                load_ack   <= 1'b1;
            end else if (fb && pending) begin
                act_value  <= sh_value;
                act_dp     <= sh_dp;
                act_blank  <= sh_blank;
                act_bright <= sh_bright;
                act_lz     <= sh_lz;
                pending    <= 1'b0;
                load_ack   <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end

            an_n        <= an_next;
            seg_n       <= seg_next;
            frame_start <= (digit_idx == '0) && (div_cnt == '0);
        end
    end

endmodule
